hier_node_collector: RTL and testbench

//  Parametrised hierarchy node, generation 2 of the generated child-fan-out nodes.

---
 rtl/hier_node_collector_if.sv | 15 +
 rtl/hier_node_collector.sv | 145 ++++++++++++++
 tb/tb_hier_node_collector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hier_node_collector_if.sv
// Report stream from a hierarchy node toward its parent: one valid/ready
// beat per report, carrying the channel id, its count and a saturation flag.
interface hier_node_collector_if #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport master (output out_valid, out_id, out_count, out_sat, input  out_ready);
  modport slave  (input  out_valid, out_id, out_count, out_sat, output out_ready);
endinterface

// File: rtl/hier_node_collector.sv
// Hierarchy node: NUM_CH saturating event counters raise reports at THRESH or on
// flush; a round-robin arbiter serialises them onto one valid/ready stream.
module hier_node_collector_ch #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             flush,
  input  logic             gnt,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             pend
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             sat_d, sat_q;
  logic             pend_d, pend_q;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (gnt) begin
      // an event landing in the grant cycle starts the next report
      cnt_d = inc ? CNT_W'(1) : '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
    // cnt_d is non-zero exactly when there is something to flush
    pend_d = (pend_q & ~gnt) | (cnt_d >= THR) | (flush & (cnt_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      pend_q <= pend_d;
    end
  end

  assign cnt  = cnt_q;
  assign sat  = sat_q;
  assign pend = pend_q;
endmodule

module hier_node_collector #(
  parameter int NUM_CH = 15,
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    ch_evt,
  input  logic [NUM_CH-1:0]    ch_flush,
  output logic [NUM_CH-1:0]    pend,
  hier_node_collector_if.master out_if
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]            sat;
  logic [NUM_CH-1:0]            gnt;
  logic [ID_W-1:0]              gnt_id;
  logic                         gnt_vld, take;
  logic [ID_W-1:0]              ptr_d, ptr_q;
  logic                         out_valid_d, out_valid_q;
  logic [ID_W-1:0]              out_id_d, out_id_q;
  logic [CNT_W-1:0]             out_count_d, out_count_q;
  logic                         out_sat_d, out_sat_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hier_node_collector_ch #(.CNT_W(CNT_W), .THRESH(THRESH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ch_evt[i] & en),
      .flush (ch_flush[i]),
      .gnt   (gnt[i]),
      .cnt   (cnt[i]),
      .sat   (sat[i]),
      .pend  (pend[i])
    );
  end

  // Lowest pending index overall, overridden by the lowest one at or above ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pend[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(i);
      end
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pend[i] && ID_W'(i) >= ptr_q) gnt_id = ID_W'(i);
  end

  always_comb begin
    take        = gnt_vld & (~out_valid_q | out_if.out_ready);
    gnt         = '0;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q & ~out_if.out_ready;
    out_id_d    = out_id_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (take) begin
      gnt[gnt_id] = 1'b1;
      ptr_d       = (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + ID_W'(1);
      out_valid_d = 1'b1;
      out_id_d    = gnt_id;
      out_count_d = cnt[gnt_id];
      out_sat_d   = sat[gnt_id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_id    = out_id_q;
  assign out_if.out_count = out_count_q;
  assign out_if.out_sat   = out_sat_q;
endmodule

// File: tb/tb_hier_node_collector.sv
// Directed bench: dut_a runs the default 8-bit/THRESH=16 node, dut_b a 4-bit
// THRESH=15 node for the saturation case; both share clock and reset.
module tb_hier_node_collector;
  localparam int NCH = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en_a, en_b;
  logic [NCH-1:0] evt_a, fl_a, pend_a;
  logic [NCH-1:0] evt_b, fl_b, pend_b;
  int             n_chk = 0;
  int             n_fail = 0;

  hier_node_collector_if #(.ID_W(4), .CNT_W(8)) ifa ();
  hier_node_collector_if #(.ID_W(4), .CNT_W(4)) ifb ();

  always #5 clk = ~clk;

  hier_node_collector #(.NUM_CH(NCH), .CNT_W(8), .THRESH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .ch_evt(evt_a), .ch_flush(fl_a),
    .pend(pend_a), .out_if(ifa)
  );

  hier_node_collector #(.NUM_CH(NCH), .CNT_W(4), .THRESH(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .ch_evt(evt_b), .ch_flush(fl_b),
    .pend(pend_b), .out_if(ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_a(input string tag, input logic [3:0] id, input logic [7:0] c,
                       input logic s);
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
    chk({tag, "_id"},    32'(ifa.out_id),    32'(id));
    chk({tag, "_count"}, 32'(ifa.out_count), 32'(c));
    chk({tag, "_sat"},   32'(ifa.out_sat),   32'(s));
  endtask

  task automatic out_b(input string tag, input logic [3:0] id, input logic [3:0] c,
                       input logic s);
    chk({tag, "_valid"}, 32'(ifb.out_valid), 32'd1);
    chk({tag, "_id"},    32'(ifb.out_id),    32'(id));
    chk({tag, "_count"}, 32'(ifb.out_count), 32'(c));
    chk({tag, "_sat"},   32'(ifb.out_sat),   32'(s));
  endtask

  initial begin
    // T1: reset with every channel pulsing
    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    evt_a = '1; fl_a = '0; evt_b = '1; fl_b = '0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b0;
    step(); step(); step();
    chk("t1_rst_valid_a", 32'(ifa.out_valid), 32'd0);
    chk("t1_rst_pend_a",  32'(pend_a), 32'd0);
    chk("t1_rst_id_a",    32'(ifa.out_id), 32'd0);
    chk("t1_rst_count_a", 32'(ifa.out_count), 32'd0);
    chk("t1_rst_pend_b",  32'(pend_b), 32'd0);
    chk("t1_rst_valid_b", 32'(ifb.out_valid), 32'd0);
    rst_n = 1'b1;
    evt_a = 15'h0001; evt_b = '0;
    step();
    evt_a = '0; fl_a = 15'h0001;
    chk("t1_no_pend", 32'(pend_a), 32'd0);
    step();
    fl_a = '0;
    chk("t1_flush_pend", 32'(pend_a), 32'h1);
    step();
    out_a("t1_first", 4'd0, 8'd1, 1'b0);
    step();
    chk("t1_drop_valid", 32'(ifa.out_valid), 32'd0);

    // T2: threshold on ch 3, report two edges after the 16th event
    evt_a = 15'h0008;
    for (int k = 0; k < 16; k++) step();
    evt_a = '0;
    chk("t2_pend3", 32'(pend_a), 32'h8);
    chk("t2_not_yet", 32'(ifa.out_valid), 32'd0);
    step();
    out_a("t2_rep", 4'd3, 8'd16, 1'b0);
    chk("t2_pend_clr", 32'(pend_a), 32'd0);
    step();
    chk("t2_drop", 32'(ifa.out_valid), 32'd0);

    // bring ptr to 0 by serving ch 14
    evt_a = 15'h4000; fl_a = 15'h4000;
    step();
    evt_a = '0; fl_a = '0;
    step();
    out_a("t3_pre14", 4'd14, 8'd1, 1'b0);
    step();

    // T3: ch 0, 5, 14 pending together
    evt_a = 15'h4021; fl_a = 15'h4021;
    step();
    evt_a = '0; fl_a = '0;
    chk("t3_pend", 32'(pend_a), 32'h4021);
    step(); out_a("t3_r0", 4'd0, 8'd1, 1'b0);
    step(); out_a("t3_r5", 4'd5, 8'd1, 1'b0);
    step(); out_a("t3_r14", 4'd14, 8'd1, 1'b0);
    step();
    chk("t3_drop", 32'(ifa.out_valid), 32'd0);
    evt_a = 15'h0021; fl_a = 15'h0021;
    step();
    evt_a = '0; fl_a = '0;
    step(); out_a("t3_rearm0", 4'd0, 8'd1, 1'b0);
    step(); out_a("t3_rearm5", 4'd5, 8'd1, 1'b0);
    step();

    // T4: backpressure with ch 9 counting behind the held report
    ifa.out_ready = 1'b0;
    evt_a = 15'h0004; fl_a = 15'h0004;
    step();
    evt_a = '0; fl_a = '0;
    step();
    out_a("t4_held", 4'd2, 8'd1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      evt_a = (k < 3)  ? 15'h0200 : '0;
      fl_a  = (k == 3) ? 15'h0200 : '0;
      step();
      out_a("t4_hold", 4'd2, 8'd1, 1'b0);
    end
    evt_a = '0; fl_a = '0;
    chk("t4_pend9", 32'(pend_a), 32'h200);
    ifa.out_ready = 1'b1;
    step();
    out_a("t4_after", 4'd9, 8'd3, 1'b0);
    step();
    chk("t4_drop", 32'(ifa.out_valid), 32'd0);

    // T5: saturation and flush on the 4-bit node while it is busy
    evt_b = 15'h0001; fl_b = 15'h0001;
    step();
    evt_b = '0; fl_b = '0;
    step();
    out_b("t5_busy", 4'd0, 4'd1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      evt_b = 15'h0004 | ((k < 2) ? 15'h0080 : 15'h0);
      fl_b  = (k == 5) ? 15'h0080 : '0;
      step();
    end
    evt_b = '0; fl_b = '0;
    chk("t5_pend", 32'(pend_b), 32'h84);
    out_b("t5_still", 4'd0, 4'd1, 1'b0);
    ifb.out_ready = 1'b1;
    step(); out_b("t5_sat2", 4'd2, 4'd15, 1'b1);
    step(); out_b("t5_fl7", 4'd7, 4'd2, 1'b0);
    step();
    chk("t5_drop", 32'(ifb.out_valid), 32'd0);
    fl_b = 15'h0100;
    step();
    fl_b = '0;
    chk("t5_empty_pend", 32'(pend_b), 32'd0);
    step();
    chk("t5_empty_valid", 32'(ifb.out_valid), 32'd0);

    // T6: event on ch 1 in its own grant cycle
    evt_a = 15'h0002; fl_a = 15'h0002;
    step();
    fl_a = '0;
    step();
    out_a("t6_grant", 4'd1, 8'd1, 1'b0);
    evt_a = '0; fl_a = 15'h0002;
    step();
    fl_a = '0;
    chk("t6_drop", 32'(ifa.out_valid), 32'd0);
    chk("t6_pend1", 32'(pend_a), 32'h2);
    step();
    out_a("t6_left", 4'd1, 8'd1, 1'b0);
    ifa.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(ifa.out_valid), 32'd0);
    chk("t6_async_pend",  32'(pend_a), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_no_replay", 32'(ifa.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
